// File: rtl/ahb_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_slave_if -- AHB-to-APB bridge front end.
//
// Decodes the AHB address against a window of NUM_SEL equally sized regions
// starting at BASE_ADDR, producing a one-hot APB select. It also registers
// address, write data and direction for the APB side, and runs a small
// handshake FSM that drives hready_out/hresp.
//
// Optional feature macro: AHB_SLV_ERR_RESP_EN
//   defined   : an unmapped active transfer gets a two-cycle ERROR response
//               (ERR1 then ERR2), and err_cnt counts these errors, saturating.
//   undefined : unmapped transfers are ignored, hresp is always OKAY and
//               err_cnt is always 0.
//
// Ports
//   hclk, hreset        clock, asynchronous active-high reset
//   hwrite, hready_in   AHB direction and bus ready
//   htrans, haddr       AHB transfer type and address
//   hwdata              AHB write data
//   prdata, apb_done    APB read data, APB transfer complete
//   haddr1/haddr2       address delayed by one and two accepted cycles
//   hwdata1/hwdata2     write data delayed by one and two accepted cycles
//   hwrite_reg          registered hwrite
//   valid               mapped active transfer (combinational)
//   temp_selx, sel_reg  one-hot select, combinational and registered
//   hrdata              AHB read data (prdata passed straight through)
//   hready_out, hresp   slave ready and response
//   err_cnt             saturating count of decode errors
// ---------------------------------------------------------------------------
module ahb_slave_if #(
  parameter int                NUM_SEL     = 3,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] REGION_SIZE = 32'h0400_0000
) (
  input  logic                hclk,
  input  logic                hreset,
  input  logic                hwrite,
  input  logic                hready_in,
  input  logic [1:0]          htrans,
  input  logic [ADDR_W-1:0]   haddr,
  input  logic [DATA_W-1:0]   hwdata,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                apb_done,
  output logic [ADDR_W-1:0]   haddr1,
  output logic [ADDR_W-1:0]   haddr2,
  output logic [DATA_W-1:0]   hwdata1,
  output logic [DATA_W-1:0]   hwdata2,
  output logic                hwrite_reg,
  output logic                valid,
  output logic [NUM_SEL-1:0]  temp_selx,
  output logic [NUM_SEL-1:0]  sel_reg,
  output logic [DATA_W-1:0]   hrdata,
  output logic                hready_out,
  output logic [1:0]          hresp,
  output logic [7:0]          err_cnt
);

  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AHB_SLV_ERR_RESP_EN
  localparam logic [1:0] RESP_ERR  = 2'b01;
`endif

  // Window arithmetic is done at 64 bits so BASE + NUM_SEL*REGION never wraps.
  localparam int         SH      = $clog2(REGION_SIZE);
  localparam logic [63:0] BASE64  = 64'(BASE_ADDR);
  localparam logic [63:0] LIMIT64 = BASE64 + (64'(NUM_SEL) * 64'(REGION_SIZE));

`ifdef AHB_SLV_ERR_RESP_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR1, S_ERR2} state_t;
`else
  typedef enum logic {S_IDLE, S_BUSY} state_t;
`endif

  state_t              r_state;
  state_t              w_next;
  logic [63:0]         w_addr64;
  logic [63:0]         w_off64;
  logic [63:0]         w_idx;
  logic                w_mapped;
  logic                w_active;
  logic                w_accept;
  logic                w_hready_out;
  logic [1:0]          w_hresp;
  logic [NUM_SEL-1:0]  w_sel;

  logic [ADDR_W-1:0]   r_haddr_p1;
  logic [ADDR_W-1:0]   r_haddr_p2;
  logic [DATA_W-1:0]   r_hwdata_p1;
  logic [DATA_W-1:0]   r_hwdata_p2;
  logic                r_hwrite_p1;
  logic [NUM_SEL-1:0]  r_sel_p1;

  // ---- Stage 0: combinational decode --------------------------------------
  assign w_addr64 = 64'(haddr);
  assign w_mapped = (w_addr64 >= BASE64) && (w_addr64 < LIMIT64);
  assign w_off64  = w_addr64 - BASE64;
  // REGION_SIZE is a power of two, so the region index is a plain shift.
  assign w_idx    = w_off64 >> SH;
  assign w_active = ((htrans == HT_NONSEQ) || (htrans == HT_SEQ)) && hready_in;

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NUM_SEL; k++) begin
      if (w_mapped && (w_idx == 64'(k))) w_sel[k] = 1'b1;
    end
  end

  assign temp_selx = w_sel;
  assign valid     = w_active && w_mapped;
  assign hrdata    = prdata;

  // ---- Stage 1/2: address, data and select pipeline (held in wait states) --
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_haddr_p1  <= '0;
      r_haddr_p2  <= '0;
      r_hwdata_p1 <= '0;
      r_hwdata_p2 <= '0;
      r_hwrite_p1 <= 1'b0;
      r_sel_p1    <= '0;
    end else if (hready_in) begin
      r_haddr_p1  <= haddr;
      r_haddr_p2  <= r_haddr_p1;
      r_hwdata_p1 <= hwdata;
      r_hwdata_p2 <= r_hwdata_p1;
      r_hwrite_p1 <= hwrite;
      r_sel_p1    <= w_sel;
    end
  end

  assign haddr1     = r_haddr_p1;
  assign haddr2     = r_haddr_p2;
  assign hwdata1    = r_hwdata_p1;
  assign hwdata2    = r_hwdata_p2;
  assign hwrite_reg = r_hwrite_p1;
  assign sel_reg    = r_sel_p1;

  // ---- Handshake FSM -------------------------------------------------------
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_hready_out = 1'b1;
    w_hresp      = RESP_OKAY;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: w_accept = 1'b1;
      S_BUSY: begin
        w_hready_out = apb_done;
        w_accept     = apb_done;
      end
`ifdef AHB_SLV_ERR_RESP_EN
      S_ERR1: begin
        w_hready_out = 1'b0;
        w_hresp      = RESP_ERR;
        w_next       = S_ERR2;
      end
      // The second error cycle completes the error and can start a new transfer.
      S_ERR2: begin
        w_hresp  = RESP_ERR;
        w_accept = 1'b1;
      end
`endif
      default: w_accept = 1'b1;
    endcase
    if (w_accept) begin
      if (valid)                      w_next = S_BUSY;
`ifdef AHB_SLV_ERR_RESP_EN
      else if (w_active && !w_mapped) w_next = S_ERR1;
`endif
      else                            w_next = S_IDLE;
    end
  end

  assign hready_out = w_hready_out;
  assign hresp      = w_hresp;

`ifdef AHB_SLV_ERR_RESP_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] r_err_cnt;

  // ERR1 is only ever entered from a non-ERR1 state, so this counts entries.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)                r_err_cnt <= 8'd0;
    else if (w_next == S_ERR1) r_err_cnt <= sat_inc8(r_err_cnt);
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 8'd0;
`endif

endmodule
